// File: rtl/user_io_pkg.sv
// rtl/user_io_pkg.sv - command codes, core type codes and channel decode for user_io_mc
package user_io_pkg;

    localparam logic [7:0] CMD_BUT_SW  = 8'h01;
    localparam logic [7:0] CMD_JOY0    = 8'h02;
    localparam logic [7:0] CMD_JOY1    = 8'h03;
    localparam logic [7:0] CMD_STATUS  = 8'h0F;
    localparam logic [7:0] CMD_JOY_EXT = 8'h10;

    localparam logic [7:0] CORE_TYPE_55 = 8'h55;
    localparam logic [7:0] CORE_TYPE_A0 = 8'hA0;
    localparam logic [7:0] CORE_TYPE_A1 = 8'hA1;
    localparam logic [7:0] CORE_TYPE_A2 = 8'hA2;
    localparam logic [7:0] CORE_TYPE_A3 = 8'hA3;
    localparam logic [7:0] CORE_TYPE_A4 = 8'hA4;
    localparam logic [7:0] CORE_TYPE_A5 = 8'hA5;
    localparam logic [7:0] CORE_TYPE_A6 = 8'hA6;

    // Marker for "command addresses no joystick channel"; larger than any legal NUM_JOY.
    localparam logic [3:0] NO_CHAN = 4'hF;

    // Joystick channel addressed by a command byte. Extended channels 2..5 live at 0x10..0x13.
    function automatic logic [3:0] joy_chan(input logic [7:0] cmd);
        if (cmd == CMD_JOY0)
            return 4'd0;
        if (cmd == CMD_JOY1)
            return 4'd1;
        if (cmd[7:2] == CMD_JOY_EXT[7:2])
            return 4'd2 + {2'b00, cmd[1:0]};
        return NO_CHAN;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-FF synchroniser for SPI clock/select/data with rise/fall event pulses
// Ports: CLK, RESET (sync, active high); spi_clk, spi_ss, spi_mosi raw pins;
//        ss_sync, mosi_sync synchronised levels; rise, fall one-CLK SPI clock edge events.
module spi_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic spi_clk,
    input  logic spi_ss,
    input  logic spi_mosi,
    output logic ss_sync,
    output logic mosi_sync,
    output logic rise,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] ss_ff;
    logic [1:0] mosi_ff;
    logic       clk_prev;
    logic       rise_q;
    logic       fall_q;

    // Select resets to "asserted" so that a transfer already running when reset
    // is released is never mistaken for an idle bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_ff   <= 2'b00;
            ss_ff    <= 2'b00;
            mosi_ff  <= 2'b00;
            clk_prev <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            clk_ff   <= {clk_ff[0], spi_clk};
            ss_ff    <= {ss_ff[0], spi_ss};
            mosi_ff  <= {mosi_ff[0], spi_mosi};
            clk_prev <= clk_ff[1];
            rise_q   <= clk_ff[1] & ~clk_prev;
            fall_q   <= ~clk_ff[1] & clk_prev;
        end
    end

    assign ss_sync   = ss_ff[1];
    assign mosi_sync = mosi_ff[1];
    assign rise      = rise_q;
    assign fall      = fall_q;

endmodule

// File: rtl/user_io_mc.sv
// rtl/user_io_mc.sv - multi-channel SPI user-I/O slave: joysticks, buttons/switches, status read-back
// Ports: CLK, RESET (sync, active high); SPI_CLK, SPI_SS_IO, SPI_MOSI, SPI_MISO slave SPI link;
//        STATUS core status byte; JOY packed joystick channels, JOY_STB commit strobes;
//        BUTTONS, SWITCHES from the button/switch register.
module user_io_mc
    import user_io_pkg::*;
#(
    parameter logic [7:0] CORE_TYPE = 8'hA4,
    parameter int         NUM_JOY   = 2,
    parameter int         JOY_WIDTH = 6
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           SPI_CLK,
    input  logic                           SPI_SS_IO,
    input  logic                           SPI_MOSI,
    inout  wire                            SPI_MISO,
    input  logic [7:0]                     STATUS,
    output logic [NUM_JOY*JOY_WIDTH-1:0]   JOY,
    output logic [NUM_JOY-1:0]             JOY_STB,
    output logic [1:0]                     BUTTONS,
    output logic [1:0]                     SWITCHES
);

    // Byte index holding the final joystick payload byte.
    localparam logic [1:0] JOY_LAST = (JOY_WIDTH <= 8) ? 2'd1 : 2'd2;

    logic                         ss_s;
    logic                         mosi_s;
    logic                         rise;
    logic                         fall;

    logic [2:0]                   bit_cnt;
    logic [1:0]                   byte_cnt;
    logic [7:0]                   shift_q;
    logic [7:0]                   cmd_q;
    logic [7:0]                   hold_q;
    logic [7:0]                   lo_q;
    logic [3:0]                   but_sw_q;
    logic [NUM_JOY*JOY_WIDTH-1:0] joy_q;
    logic [NUM_JOY-1:0]           stb_q;
    logic                         miso_q;
    logic                         armed;

    logic [7:0]                   byte_in;
    logic [3:0]                   chan;
    logic                         joy_commit;
    logic [7:0]                   miso_src;
    logic [JOY_WIDTH-1:0]         joy_val;

    spi_edge_sync u_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .spi_clk   (SPI_CLK),
        .spi_ss    (SPI_SS_IO),
        .spi_mosi  (SPI_MOSI),
        .ss_sync   (ss_s),
        .mosi_sync (mosi_s),
        .rise      (rise),
        .fall      (fall)
    );

    assign byte_in = {shift_q[6:0], mosi_s};
    assign chan    = joy_chan(cmd_q);

    // Payload is assembled from the low byte latched earlier plus the byte finishing now,
    // so the joystick register is written once, on the last byte.
    generate
        if (JOY_WIDTH <= 8) begin : g_one_byte
            assign joy_val = byte_in[JOY_WIDTH-1:0];
        end else begin : g_two_byte
            assign joy_val = JOY_WIDTH'({byte_in, lo_q});
        end
    endgenerate

    assign joy_commit = (bit_cnt == 3'd7) && (byte_cnt == JOY_LAST) && (int'(chan) < NUM_JOY);

    // Status is returned only after the command byte selected it; everything else echoes the core type.
    assign miso_src = ((byte_cnt != 2'd0) && (cmd_q == CMD_STATUS)) ? hold_q : CORE_TYPE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            shift_q  <= 8'h00;
            cmd_q    <= 8'h00;
            hold_q   <= 8'h00;
            lo_q     <= 8'h00;
            but_sw_q <= 4'h0;
            joy_q    <= '0;
            stb_q    <= '0;
            miso_q   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            stb_q <= '0;
            if (ss_s) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 2'd0;
                armed    <= 1'b1;
                // First bit of the next command byte must be on the wire before the first rising edge.
                miso_q   <= CORE_TYPE[7];
            end else if (armed) begin
                if (rise) begin
                    shift_q <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt != 2'd3)
                            byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd0) begin
                            cmd_q  <= byte_in;
                            hold_q <= STATUS;
                        end
                        if (byte_cnt == 2'd1) begin
                            lo_q <= byte_in;
                            if (cmd_q == CMD_BUT_SW)
                                but_sw_q <= byte_in[3:0];
                        end
                    end
                    for (int n = 0; n < NUM_JOY; n++) begin
                        if (joy_commit && (chan == 4'(n))) begin
                            joy_q[n*JOY_WIDTH +: JOY_WIDTH] <= joy_val;
                            stb_q[n]                        <= 1'b1;
                        end
                    end
                end
                if (fall)
                    miso_q <= miso_src[~bit_cnt];
            end
        end
    end

    assign JOY      = joy_q;
    assign JOY_STB  = stb_q;
    assign BUTTONS  = but_sw_q[1:0];
    assign SWITCHES = but_sw_q[3:2];
    assign SPI_MISO = SPI_SS_IO ? 1'bz : miso_q;

endmodule

// File: tb/tb_user_io_mc.sv
// tb/tb_user_io_mc.sv - directed self-checking bench for user_io_mc (6-bit x2 and 12-bit x4 instances)
module tb_user_io_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic [7:0]  status;
    wire         miso_a;
    wire         miso_b;

    logic [11:0] joy_a;
    logic [1:0]  stb_a;
    logic [1:0]  but_a;
    logic [1:0]  sw_a;
    logic [47:0] joy_b;
    logic [3:0]  stb_b;
    logic [1:0]  but_b;
    logic [1:0]  sw_b;

    int checks = 0;
    int errors = 0;
    int stb_cnt_a [2];
    int stb_cnt_b [4];
    int exp_a [2];
    int exp_b [4];
    logic [7:0] ra;
    logic [7:0] rb;

    always #5 clk = ~clk;

    user_io_mc #(.CORE_TYPE(8'hA4), .NUM_JOY(2), .JOY_WIDTH(6)) u_a (
        .CLK(clk), .RESET(rst), .SPI_CLK(sclk), .SPI_SS_IO(ss), .SPI_MOSI(mosi),
        .SPI_MISO(miso_a), .STATUS(status), .JOY(joy_a), .JOY_STB(stb_a),
        .BUTTONS(but_a), .SWITCHES(sw_a)
    );

    user_io_mc #(.CORE_TYPE(8'hA6), .NUM_JOY(4), .JOY_WIDTH(12)) u_b (
        .CLK(clk), .RESET(rst), .SPI_CLK(sclk), .SPI_SS_IO(ss), .SPI_MOSI(mosi),
        .SPI_MISO(miso_b), .STATUS(status), .JOY(joy_b), .JOY_STB(stb_b),
        .BUTTONS(but_b), .SWITCHES(sw_b)
    );

    // Strobe cycles are tallied per channel so a pulse that is missing, repeated or
    // stretched shows up as a count mismatch.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) if (stb_a[n]) stb_cnt_a[n]++;
        for (int n = 0; n < 4; n++) if (stb_b[n]) stb_cnt_b[n]++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stb(input string tag);
        for (int n = 0; n < 2; n++)
            check($sformatf("%s_stb_a%0d", tag, n), 64'(stb_cnt_a[n]), 64'(exp_a[n]));
        for (int n = 0; n < 4; n++)
            check($sformatf("%s_stb_b%0d", tag, n), 64'(stb_cnt_b[n]), 64'(exp_b[n]));
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 master: data set while SCLK low, MISO sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] qa, output logic [7:0] qb);
        qa = 8'h00;
        qb = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            clks(6);
            qa[i] = miso_a;
            qb[i] = miso_b;
            sclk = 1'b1;
            clks(6);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] qa, output logic [7:0] qb);
        spi_bits(b, 8, qa, qb);
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        clks(6);
    endtask

    task automatic ss_end();
        clks(2);
        ss = 1'b1;
        clks(8);
    endtask

    initial begin
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; status = 8'h00;
        clks(4);
        check("rst_joy_a", joy_a, 0);
        check("rst_joy_b", joy_b, 0);
        check("rst_but_sw", {but_a, sw_a, but_b, sw_b}, 0);
        check("rst_stb", {stb_a, stb_b}, 0);
        rst = 1'b0;
        clks(6);

        // Joystick 0, single byte payload on the 6-bit instance.
        ss_begin();
        spi_byte(8'h02, ra, rb);
        check("t1_miso0_a", ra, 8'hA4);
        check("t1_miso0_b", rb, 8'hA6);
        spi_byte(8'h2A, ra, rb);
        check("t1_miso1_a", ra, 8'hA4);
        ss_end();
        exp_a[0]++;
        check("t1_joy_a", joy_a, 12'h02A);
        check("t1_joy_b0", joy_b[11:0], 12'h000);
        check_stb("t1");

        // Extended channel 3 with a two-byte payload; the 2-channel instance must ignore it.
        ss_begin();
        spi_byte(8'h11, ra, rb);
        spi_byte(8'hCD, ra, rb);
        check("t2_mid_b3", joy_b[47:36], 12'h000);
        check_stb("t2_mid");
        spi_byte(8'h0B, ra, rb);
        exp_b[3]++;
        check("t2_joy_b3", joy_b[47:36], 12'hBCD);
        ss_end();
        check("t2_joy_a", joy_a, 12'h02A);
        check_stb("t2");

        // Buttons and switches.
        ss_begin();
        spi_byte(8'h01, ra, rb);
        spi_byte(8'h0E, ra, rb);
        ss_end();
        check("t3_but_a", but_a, 2'b10);
        check("t3_sw_a", sw_a, 2'b11);
        check("t3_but_b", but_b, 2'b10);
        check("t3_sw_b", sw_b, 2'b11);

        // Status read-back with one dummy byte.
        status = 8'h5A;
        ss_begin();
        spi_byte(8'h0F, ra, rb);
        check("t4_miso0_a", ra, 8'hA4);
        check("t4_miso0_b", rb, 8'hA6);
        spi_byte(8'h00, ra, rb);
        check("t4_miso1_a", ra, 8'h5A);
        check("t4_miso1_b", rb, 8'h5A);
        ss_end();
        check("t4_joy_a", joy_a, 12'h02A);
        check("t4_joy_b", joy_b, 48'hBCD_000_000_000);
        check("t4_but_sw", {but_a, sw_a, but_b, sw_b}, 8'b1011_1011);
        check_stb("t4");

        // Select raised after 5 payload bits, then a full transfer; extra byte is beyond 6-bit payload.
        ss_begin();
        spi_byte(8'h03, ra, rb);
        spi_bits(8'h15, 5, ra, rb);
        ss_end();
        check("t5_abort_a", joy_a, 12'h02A);
        check("t5_abort_b1", joy_b[23:12], 12'h000);
        check_stb("t5_abort");
        ss_begin();
        spi_byte(8'h03, ra, rb);
        spi_byte(8'h15, ra, rb);
        spi_byte(8'hF7, ra, rb);
        ss_end();
        exp_a[1]++;
        exp_b[1]++;
        check("t5_joy_a", joy_a, 12'h56A);
        check("t5_joy_b1", joy_b[23:12], 12'h715);
        check_stb("t5");

        // Reset in the middle of a payload, with bits continuing while select stays low.
        ss_begin();
        spi_byte(8'h02, ra, rb);
        spi_bits(8'h3F, 4, ra, rb);
        rst = 1'b1;
        clks(3);
        check("t6_rst_joy_a", joy_a, 0);
        check("t6_rst_joy_b", joy_b, 0);
        check("t6_rst_but_sw", {but_a, sw_a, but_b, sw_b}, 0);
        check("t6_rst_miso", {miso_a, miso_b}, 2'b00);
        rst = 1'b0;
        clks(2);
        spi_byte(8'hF3, ra, rb);
        spi_byte(8'h33, ra, rb);
        spi_byte(8'h33, ra, rb);
        check("t6_ign_joy_a", joy_a, 0);
        check("t6_ign_joy_b", joy_b, 0);
        check("t6_ign_miso", {ra, rb}, 16'h0000);
        check_stb("t6_ign");
        ss_end();
        ss_begin();
        spi_byte(8'h02, ra, rb);
        check("t6_miso0_a", ra, 8'hA4);
        spi_byte(8'h21, ra, rb);
        spi_byte(8'h04, ra, rb);
        ss_end();
        exp_a[0]++;
        exp_b[0]++;
        check("t6_joy_a", joy_a, 12'h021);
        check("t6_joy_b", joy_b, 48'h000_000_000_421);
        check_stb("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
